router_input_unit: RTL

ROUTER_INPUT_UNIT -- requirements
Module: router_input_unit

---
 rtl/router_input_unit_pkg.sv | 41 ++++
 rtl/xy_route_calc.sv | 40 ++++
 rtl/router_input_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/router_input_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : router_input_unit_pkg                                        |
// | Description : Shared constants for mesh router input units: flit width,    |
// |               destination coordinate field positions and output port       |
// |               indices used by the XY route calculator.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package router_input_unit_pkg;

   // Flit geometry: [19:18] dest X, [17:16] dest Y, [15:0] payload
   localparam int FLIT_W    = 20;
   localparam int COORD_W   = 2;
   localparam int DEST_X_HI = 19;
   localparam int DEST_X_LO = 18;
   localparam int DEST_Y_HI = 17;
   localparam int DEST_Y_LO = 16;
   localparam int PAYLOAD_W = 16;

   // Output port indices into the one-hot port request vector
   localparam int NUM_PORTS = 5;
   localparam int LOCAL     = 0;
   localparam int NORTH     = 1;
   localparam int SOUTH     = 2;
   localparam int EAST      = 3;
   localparam int WEST      = 4;

   typedef logic [FLIT_W-1:0]    flit_t;
   typedef logic [NUM_PORTS-1:0] port_vec_t;
   typedef logic [COORD_W-1:0]   coord_t;

   function automatic coord_t flit_dest_x(input flit_t f);
      return f[DEST_X_HI:DEST_X_LO];
   endfunction

   function automatic coord_t flit_dest_y(input flit_t f);
      return f[DEST_Y_HI:DEST_Y_LO];
   endfunction

endpackage
`default_nettype wire

// File: rtl/xy_route_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xy_route_calc                                                |
// | Description : Combinational dimension-ordered (X then Y) route selection.  |
// |               Ports:                                                       |
// |                 dest_x, dest_y : destination coordinates of the flit       |
// |                 port_req       : one-hot output port request              |
// |               Parameters X_ID / Y_ID give this router's mesh position.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module xy_route_calc
   import router_input_unit_pkg::*;
#(
   parameter logic [COORD_W-1:0] X_ID = '0,
   parameter logic [COORD_W-1:0] Y_ID = '0
) (
   input  logic [COORD_W-1:0]   dest_x,
   input  logic [COORD_W-1:0]   dest_y,
   output logic [NUM_PORTS-1:0] port_req
);

   // X is resolved fully before Y is considered; this ordering is what keeps
   // XY routing deadlock-free in a mesh.
   always_comb begin
      port_req = '0;
      if (dest_x > X_ID) begin
         port_req[EAST] = 1'b1;
      end else if (dest_x < X_ID) begin
         port_req[WEST] = 1'b1;
      end else if (dest_y > Y_ID) begin
         port_req[SOUTH] = 1'b1;
      end else if (dest_y < Y_ID) begin
         port_req[NORTH] = 1'b1;
      end else begin
         port_req[LOCAL] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/router_input_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : router_input_unit                                            |
// | Description : Credit-based router input buffer. Flits are queued in a      |
// |               circular FIFO; the head flit is presented with its XY route  |
// |               request, and one credit is returned per flit popped.         |
// |               Ports:                                                       |
// |                 clk, RST     : clock, asynchronous active-high reset       |
// |                 datain       : incoming flit, in_valid qualifies it       |
// |                 co           : credit return pulse (one per pop)          |
// |                 flit_out     : head-of-buffer flit, flit_valid if present |
// |                 port_req     : one-hot route request for the head flit    |
// |                 grant        : allocator accepts the head flit            |
// |                 occupancy    : number of buffered flits                   |
// |                 overflow_err : sticky, set when a flit arrived while full |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module router_input_unit
   import router_input_unit_pkg::*;
#(
   parameter int                 DEPTH = 4,
   parameter logic [COORD_W-1:0] X_ID  = '0,
   parameter logic [COORD_W-1:0] Y_ID  = '0
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic [FLIT_W-1:0]    datain,
   input  logic                 in_valid,
   output logic                 co,
   output logic [FLIT_W-1:0]    flit_out,
   output logic                 flit_valid,
   output logic [NUM_PORTS-1:0] port_req,
   input  logic                 grant,
   output logic [2:0]           occupancy,
   output logic                 overflow_err
);

   localparam int               c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
   localparam logic [2:0]       c_depth    = 3'(DEPTH);

   logic [FLIT_W-1:0]    r_mem [DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [2:0]           r_count;
   logic [FLIT_W-1:0]    r_head;
   logic                 r_co;
   logic                 r_overflow;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic [c_ptr_w-1:0]   w_wr_ptr_inc;
   logic [c_ptr_w-1:0]   w_rd_ptr_inc;
   logic [2:0]           w_count_next;
   logic [FLIT_W-1:0]    w_head_next;
   logic [NUM_PORTS-1:0] w_route;

   // Pointers wrap explicitly so non-power-of-two depths work as well.
   function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
      return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
   endfunction

   assign w_empty      = (r_count == 3'd0);
   assign w_full       = (r_count == c_depth);
   assign w_pop        = grant && !w_empty;
   // A pop in the same cycle frees a slot, so a full buffer still accepts.
   assign w_push       = in_valid && (!w_full || w_pop);
   assign w_drop       = in_valid && !w_push;
   assign w_wr_ptr_inc = ptr_inc(r_wr_ptr);
   assign w_rd_ptr_inc = ptr_inc(r_rd_ptr);

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 3'd1;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - 3'd1;
      end
   end

   // The head register holds the entry that will sit at the read pointer
   // after this edge. When the buffer is (or drains to) a single entry that is
   // being written this cycle, the new flit bypasses the array into the head
   // register so it is visible one cycle after it arrives.
   always_comb begin
      w_head_next = r_head;
      if (w_pop) begin
         if (r_count > 3'd1) begin
            w_head_next = r_mem[w_rd_ptr_inc];
         end else if (w_push) begin
            w_head_next = datain;
         end
      end else if (w_push && w_empty) begin
         w_head_next = datain;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_head     <= '0;
         r_co       <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= datain;
            r_wr_ptr        <= w_wr_ptr_inc;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
         r_count <= w_count_next;
         r_head  <= w_head_next;
         // Credit follows each pop by one cycle; dropped flits never earn one.
         r_co    <= w_pop;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   xy_route_calc #(
      .X_ID (X_ID),
      .Y_ID (Y_ID)
   ) u_xy_route_calc (
      .dest_x   (flit_dest_x(r_head)),
      .dest_y   (flit_dest_y(r_head)),
      .port_req (w_route)
   );

   assign flit_out     = r_head;
   assign flit_valid   = !w_empty;
   assign port_req     = w_empty ? '0 : w_route;
   assign co           = r_co;
   assign occupancy    = r_count;
   assign overflow_err = r_overflow;

endmodule
`default_nettype wire
